wb_stage_trace: RTL and testbench



---
 rtl/wb_stage_trace_pkg.sv | 34 +++
 rtl/wb_stage_trace_if.sv | 43 ++++
 rtl/wb_stage_trace_fifo.sv | 55 +++++
 rtl/wb_stage_trace.sv | 119 +++++++++++
 tb/tb_wb_stage_trace.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_trace_pkg.sv
// Shared defaults and bus/trace layout helpers for the writeback stage.
// The MEM->WB bus is {rf_we, dest, result, pc}, MSB first.
package wb_stage_trace_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_PC_W        = 32;
  localparam int DEF_RADDR_W     = 5;
  localparam int DEF_TRACE_DEPTH = 4;
  localparam int DEF_RETIRE_W    = 32;

  function automatic int ms_ws_bus_w(input int raddr_w, input int data_w, input int pc_w);
    return 1 + raddr_w + data_w + pc_w;
  endfunction

  // Trace entry is {pc, wen[3:0], dest, result}
  function automatic int trace_entry_w(input int raddr_w, input int data_w, input int pc_w);
    return pc_w + 4 + raddr_w + data_w;
  endfunction

  function automatic int bus_result_lsb(input int pc_w);
    return pc_w;
  endfunction

  function automatic int bus_dest_lsb(input int data_w, input int pc_w);
    return pc_w + data_w;
  endfunction

  function automatic int bus_we_bit(input int raddr_w, input int data_w, input int pc_w);
    return pc_w + data_w + raddr_w;
  endfunction

  localparam int DEF_MS_WS_BUS_W = 1 + DEF_RADDR_W + DEF_DATA_W + DEF_PC_W;

endpackage

// File: rtl/wb_stage_trace_if.sv
// Bundle of MEM handshake, regfile/forwarding outputs and trace port of the WB stage.
interface wb_stage_trace_if import wb_stage_trace_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PC_W     = DEF_PC_W,
  parameter int RADDR_W  = DEF_RADDR_W,
  parameter int RETIRE_W = DEF_RETIRE_W
) ();

  localparam int BUS_W = 1 + RADDR_W + DATA_W + PC_W;

  logic                ms_valid;
  logic [BUS_W-1:0]    ms_to_ws_bus;
  logic                ws_allowin;
  logic                ws_valid;
  logic                rf_we;
  logic [RADDR_W-1:0]  rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                fwd_valid;
  logic [RADDR_W-1:0]  fwd_addr;
  logic [DATA_W-1:0]   fwd_data;
  logic                trace_valid;
  logic                trace_ready;
  logic [PC_W-1:0]     trace_pc;
  logic [3:0]          trace_wen;
  logic [RADDR_W-1:0]  trace_wnum;
  logic [DATA_W-1:0]   trace_wdata;
  logic [RETIRE_W-1:0] retire_cnt;

  modport master (
    output ms_valid, ms_to_ws_bus, trace_ready,
    input  ws_allowin, ws_valid, rf_we, rf_waddr, rf_wdata,
           fwd_valid, fwd_addr, fwd_data,
           trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata, retire_cnt
  );

  modport slave (
    input  ms_valid, ms_to_ws_bus, trace_ready,
    output ws_allowin, ws_valid, rf_we, rf_waddr, rf_wdata,
           fwd_valid, fwd_addr, fwd_data,
           trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata, retire_cnt
  );

endinterface

// File: rtl/wb_stage_trace_fifo.sv
// First-word-fall-through FIFO holding committed-instruction trace entries.
// Pushes while full and pops while empty are ignored.
module wb_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage_trace.sv
// Writeback stage: commits to the regfile, forwards to ID, logs every commit
// into the trace FIFO and counts retired instructions. A full FIFO stalls it.
module wb_stage_trace import wb_stage_trace_pkg::*; #(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int RADDR_W     = DEF_RADDR_W,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH,
  parameter int RETIRE_W    = DEF_RETIRE_W
) (
  input logic             clk,
  input logic             resetn,
  wb_stage_trace_if.slave wb_if
);

  localparam int BUS_W   = ms_ws_bus_w(RADDR_W, DATA_W, PC_W);
  localparam int TRACE_W = trace_entry_w(RADDR_W, DATA_W, PC_W);
  localparam int CNT_W   = $clog2(TRACE_DEPTH) + 1;
  localparam int RES_LSB = bus_result_lsb(PC_W);
  localparam int DST_LSB = bus_dest_lsb(DATA_W, PC_W);
  localparam int WE_BIT  = bus_we_bit(RADDR_W, DATA_W, PC_W);

  logic                ws_valid_q, ws_valid_d;
  logic [BUS_W-1:0]    bus_q, bus_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;

  logic                ws_ready_go;
  logic                ws_allowin;
  logic                commit;
  logic                bus_we;
  logic [RADDR_W-1:0]  bus_dest;
  logic [DATA_W-1:0]   bus_result;
  logic [PC_W-1:0]     bus_pc;
  logic [TRACE_W-1:0]  push_entry;
  logic [TRACE_W-1:0]  head_entry;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                unused_fifo_empty;

  assign bus_we     = bus_q[WE_BIT];
  assign bus_dest   = bus_q[DST_LSB +: RADDR_W];
  assign bus_result = bus_q[RES_LSB +: DATA_W];
  assign bus_pc     = bus_q[PC_W-1:0];

  // Stall decision uses only registered FIFO state, never trace_ready
  assign ws_ready_go = ~fifo_full;
  assign ws_allowin  = ~ws_valid_q | ws_ready_go;
  assign commit      = ws_valid_q & ws_ready_go;
  assign push_entry  = {bus_pc, {4{bus_we}}, bus_dest, bus_result};

  // Next-state for the pipeline register and retire counter
  always_comb begin
    ws_valid_d = ws_valid_q;
    bus_d      = bus_q;
    retire_d   = retire_q;
    if (ws_allowin) begin
      ws_valid_d = wb_if.ms_valid;
    end else begin
      ws_valid_d = ws_valid_q;
    end
    if (wb_if.ms_valid && ws_allowin) begin
      bus_d = wb_if.ms_to_ws_bus;
    end else begin
      bus_d = bus_q;
    end
    if (commit) begin
      retire_d = retire_q + RETIRE_W'(1);
    end else begin
      retire_d = retire_q;
    end
  end

  // Pipeline register and retire counter state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
      retire_q   <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      bus_q      <= bus_d;
      retire_q   <= retire_d;
    end
  end

  wb_trace_fifo #(
    .W     (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (commit),
    .pop_i   (wb_if.trace_ready),
    .din_i   (push_entry),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_fifo_empty = fifo_empty;

  assign wb_if.ws_allowin  = ws_allowin;
  assign wb_if.ws_valid    = ws_valid_q;
  assign wb_if.rf_we       = commit & bus_we;
  assign wb_if.rf_waddr    = bus_dest;
  assign wb_if.rf_wdata    = bus_result;
  // Forwarding stays up during a stall since the result is already final
  assign wb_if.fwd_valid   = ws_valid_q & bus_we & (bus_dest != '0);
  assign wb_if.fwd_addr    = bus_dest;
  assign wb_if.fwd_data    = bus_result;
  assign wb_if.trace_valid = (fifo_count != '0);
  assign wb_if.trace_pc    = head_entry[TRACE_W-1 -: PC_W];
  assign wb_if.trace_wen   = head_entry[DATA_W+RADDR_W +: 4];
  assign wb_if.trace_wnum  = head_entry[DATA_W +: RADDR_W];
  assign wb_if.trace_wdata = head_entry[DATA_W-1:0];
  assign wb_if.retire_cnt  = retire_q;

endmodule

// File: tb/tb_wb_stage_trace.sv
// Scoreboard bench for wb_stage_trace: stimulus queues expected regfile writes
// and trace entries; a negedge monitor pops and compares them as the DUT emits.
module tb_wb_stage_trace;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  int   idx;
  bit   tog_en;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  ret;
  } rf_t;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } tr_t;

  rf_t rq[$];
  tr_t tq[$];

  wb_stage_trace_if #(.DATA_W(32), .PC_W(32), .RADDR_W(5), .RETIRE_W(4)) wb_if ();

  wb_stage_trace #(
    .DATA_W(32), .PC_W(32), .RADDR_W(5), .TRACE_DEPTH(4), .RETIRE_W(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .wb_if  (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare regfile writes and trace pops against the queues
  always @(negedge clk) begin
    if (resetn) begin
      if (wb_if.rf_we) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rf_unexpected: got addr %0h data %0h expected no write",
                   wb_if.rf_waddr, wb_if.rf_wdata);
        end else begin
          rf_t e;
          e = rq.pop_front();
          chk("rf_write", {wb_if.rf_waddr, wb_if.rf_wdata, wb_if.retire_cnt},
              {e.addr, e.data, e.ret});
        end
      end
      if (wb_if.trace_valid && wb_if.trace_ready) begin
        if (tq.size() == 0) begin
          checks++; errors++;
          $display("FAIL trace_unexpected: got pc %0h expected no entry", wb_if.trace_pc);
        end else begin
          tr_t t;
          t = tq.pop_front();
          chk("trace_entry", {wb_if.trace_pc, wb_if.trace_wen, wb_if.trace_wnum, wb_if.trace_wdata},
              {t.pc, t.wen, t.wnum, t.wdata});
        end
      end
    end
  end

  // Toggles trace_ready every cycle while enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tog_en) wb_if.trace_ready = ~wb_if.trace_ready;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Call at posedge+1; returns at posedge+1 right after the MEM->WB transfer
  task automatic send(input logic we, input logic [4:0] d, input logic [31:0] data,
                      input logic [31:0] pc);
    bit ok;
    rf_t r;
    tr_t t;
    ok = 1'b0;
    wb_if.ms_valid     = 1'b1;
    wb_if.ms_to_ws_bus = {we, d, data, pc};
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (wb_if.ws_allowin) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got allowin=0 for 200 cycles expected acceptance, pc %0h", pc);
    end else begin
      if (we) begin
        r.addr = d; r.data = data; r.ret = idx[3:0];
        rq.push_back(r);
      end
      t.pc = pc; t.wen = {4{we}}; t.wnum = d; t.wdata = data;
      tq.push_back(t);
      idx++;
    end
    @(posedge clk); #1;
    wb_if.ms_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    wb_if.trace_ready = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!wb_if.trace_valid && !wb_if.ws_valid) done = 1'b1;
    end
    chk("drain_done", {127'd0, done}, 128'd1);
    step();
    wb_if.trace_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; idx = 0; tog_en = 1'b0;
    resetn = 1'b0;
    wb_if.ms_valid = 1'b0;
    wb_if.ms_to_ws_bus = '0;
    wb_if.trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin", wb_if.ws_allowin, 1'b1);
    chk("rst_ws_valid", wb_if.ws_valid, 1'b0);
    chk("rst_rf_we", wb_if.rf_we, 1'b0);
    chk("rst_fwd_valid", wb_if.fwd_valid, 1'b0);
    chk("rst_trace_valid", wb_if.trace_valid, 1'b0);
    chk("rst_retire", wb_if.retire_cnt, 4'd0);
    step();
    resetn = 1'b1;
    step();

    // First instruction commits one cycle after acceptance
    send(1'b1, 5'd3, 32'hDEADBEEF, 32'h1C000000);
    @(negedge clk);
    chk("t1_rf_we", wb_if.rf_we, 1'b1);
    chk("t1_rf_waddr", wb_if.rf_waddr, 5'd3);
    chk("t1_rf_wdata", wb_if.rf_wdata, 32'hDEADBEEF);
    chk("t1_fwd_valid", wb_if.fwd_valid, 1'b1);
    chk("t1_fwd_data", wb_if.fwd_data, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t1_trace_valid", wb_if.trace_valid, 1'b1);
    chk("t1_trace_pc", wb_if.trace_pc, 32'h1C000000);
    chk("t1_trace_wen", wb_if.trace_wen, 4'hF);
    chk("t1_retire", wb_if.retire_cnt, 4'd1);
    step();

    // Non-writing instruction still traces and retires
    send(1'b0, 5'd0, 32'h12345678, 32'h1C000004);
    @(negedge clk);
    chk("t2_rf_we", wb_if.rf_we, 1'b0);
    chk("t2_fwd_valid", wb_if.fwd_valid, 1'b0);
    step();
    @(negedge clk);
    chk("t2_retire", wb_if.retire_cnt, 4'd2);
    chk("t2_count", dut.u_fifo.count_q, 3'd2);
    step();
    drain();

    // Back-pressure: five instructions into a four-entry FIFO
    for (int i = 0; i < 5; i++)
      send(1'b1, 5'(i + 7), 32'hB0000000 + 32'(i), 32'h1C000100 + 32'(4 * i));
    @(negedge clk);
    chk("t3_ws_valid", wb_if.ws_valid, 1'b1);
    chk("t3_rf_we_stall", wb_if.rf_we, 1'b0);
    chk("t3_allowin", wb_if.ws_allowin, 1'b0);
    chk("t3_fwd_stall", {wb_if.fwd_valid, wb_if.fwd_addr}, {1'b1, 5'd11});
    chk("t3_count_full", dut.u_fifo.count_q, 3'd4);
    step();
    @(negedge clk);
    chk("t3_still_stalled", wb_if.ws_allowin, 1'b0);
    step();
    wb_if.trace_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_commit_on_pop", wb_if.rf_we, 1'b0);
    step();
    wb_if.trace_ready = 1'b0;
    @(negedge clk);
    chk("t3_commit_after_pop", wb_if.rf_we, 1'b1);
    chk("t3_allowin_after_pop", wb_if.ws_allowin, 1'b1);
    step();
    @(negedge clk);
    chk("t3_refull", dut.u_fifo.count_q, 3'd4);
    chk("t3_ws_empty", wb_if.ws_valid, 1'b0);
    step();
    drain();

    // Simultaneous push and pop at count 2
    send(1'b1, 5'd1, 32'hC0000001, 32'h1C000200);
    send(1'b1, 5'd2, 32'hC0000002, 32'h1C000204);
    send(1'b1, 5'd3, 32'hC0000003, 32'h1C000208);
    wb_if.trace_ready = 1'b1;
    @(negedge clk);
    chk("t4_count_before", dut.u_fifo.count_q, 3'd2);
    chk("t4_rf_we", wb_if.rf_we, 1'b1);
    step();
    wb_if.trace_ready = 1'b0;
    @(negedge clk);
    chk("t4_count_after", dut.u_fifo.count_q, 3'd2);
    step();
    drain();

    // Sixteen instructions with toggling consumer, crossing pointer wrap
    tog_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 5'(i), 32'hA0000000 + 32'(i), 32'h1C001000 + 32'(4 * i));
      if (i == 0) begin
        @(negedge clk);
        chk("t5_fwd_dest0", wb_if.fwd_valid, 1'b0);
        step();
      end
    end
    tog_en = 1'b0;
    drain();

    // Asynchronous reset mid-cycle with WB busy and FIFO at 3
    for (int i = 0; i < 4; i++)
      send(1'b1, 5'(i + 20), 32'hE0000000 + 32'(i), 32'h1C002000 + 32'(4 * i));
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rf_we_drop", wb_if.rf_we, 1'b0);
    chk("t6_trace_drop", wb_if.trace_valid, 1'b0);
    chk("t6_ws_valid_drop", wb_if.ws_valid, 1'b0);
    rq.delete();
    tq.delete();
    idx = 0;
    step();
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_retire_zero", wb_if.retire_cnt, 4'd0);
    chk("t6_no_trace", wb_if.trace_valid, 1'b0);
    chk("t6_no_write", wb_if.rf_we, 1'b0);
    step();

    // Retire counter wrap with a 4-bit counter
    wb_if.trace_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send(1'b1, 5'(i + 1), 32'hF0000000 + 32'(i), 32'h1C003000 + 32'(4 * i));
    step();
    step();
    @(negedge clk);
    chk("t7_retire_wrap", wb_if.retire_cnt, 4'd1);
    step();
    drain();

    chk("rf_queue_empty", 128'(rq.size()), 128'd0);
    chk("trace_queue_empty", 128'(tq.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
